// File: rtl/icache_core.sv
// Direct-mapped instruction cache with flop storage and a single-line refill engine.
// Ports: core fetch (core_request_i/core_pc_i -> core_wait_o/core_addr_o/core_out_o), inv_i flush,
//        refill master (mem_req_o/mem_addr_o/mem_gnt_i, beats on mem_rvalid_i/mem_rdata_i).
module icache_core #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_request_i,
    input  logic [31:0] core_pc_i,
    output logic        core_wait_o,
    output logic [31:0] core_addr_o,
    output logic [31:0] core_out_o,
    input  logic        inv_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int WORD_W  = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = 2 + WORD_W + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q;
    logic [31:0]         miss_addr_q;
    logic [WORD_W-1:0]   beat_cnt_q;
    logic                inv_pend_q;
    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS][LINE_WORDS];

    logic [IDX_W-1:0]    lk_idx;
    logic [WORD_W-1:0]   lk_word;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic                hit;
    logic                beat_wr;
    logic                last_beat;

    // Lookup is purely combinational on the registered fetch address.
    assign lk_word  = addr_q[2 +: WORD_W];
    assign lk_idx   = addr_q[2 + WORD_W +: IDX_W];
    assign lk_tag   = addr_q[31:TAG_LSB];
    assign fill_idx = miss_addr_q[2 + WORD_W +: IDX_W];

    assign hit       = (state_q == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign beat_wr   = (state_q == REFILL) && mem_rvalid_i;
    assign last_beat = beat_wr && (beat_cnt_q == WORD_W'(LINE_WORDS - 1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!hit)      state_d = MISS_REQ;
            MISS_REQ: if (mem_gnt_i) state_d = REFILL;
            REFILL:   if (last_beat) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        core_wait_o = ~hit;
        core_addr_o = addr_q;
        core_out_o  = hit ? data_q[lk_idx][lk_word] : 32'h0;
        mem_req_o   = (state_q == MISS_REQ);
        mem_addr_o  = miss_addr_q;
    end

    // Control datapath: fetch address, miss line, beat counter, valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= 32'h0;
            miss_addr_q <= 32'h0;
            beat_cnt_q  <= '0;
            inv_pend_q  <= 1'b0;
            valid_q     <= '0;
        end else begin
            if (core_request_i) begin
                addr_q <= core_pc_i;
            end
            if (state_q == IDLE && !hit) begin
                miss_addr_q <= {addr_q[31:2 + WORD_W], {(2 + WORD_W){1'b0}}};
            end
            if (state_q == MISS_REQ && mem_gnt_i) begin
                beat_cnt_q <= '0;
            end else if (beat_wr) begin
                beat_cnt_q <= beat_cnt_q + WORD_W'(1);
            end
            // A flush seen mid-refill must keep the incoming line invalid,
            // since its earlier beats may predate the flush.
            if (state_q != REFILL || last_beat) begin
                inv_pend_q <= 1'b0;
            end else if (inv_i) begin
                inv_pend_q <= 1'b1;
            end
            if (inv_i) begin
                valid_q <= '0;
            end else if (last_beat) begin
                valid_q[fill_idx] <= ~inv_pend_q;
            end
        end
    end

    // Line storage; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (beat_wr) begin
            data_q[fill_idx][beat_cnt_q] <= mem_rdata_i;
        end
        if (last_beat) begin
            tag_q[fill_idx] <= miss_addr_q[31:TAG_LSB];
        end
    end

endmodule

// File: tb/tb_icache_core.sv
module tb_icache_core;

    localparam int SETS       = 64;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = LINE_WORDS * 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_request_i;
    logic [31:0] core_pc_i;
    logic        core_wait_o;
    logic [31:0] core_addr_o;
    logic [31:0] core_out_o;
    logic        inv_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    // Reference model: which line address each set currently holds.
    bit          m_vld  [SETS];
    logic [31:0] m_line [SETS];
    logic [31:0] cur_pc;

    icache_core #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .core_request_i (core_request_i),
        .core_pc_i      (core_pc_i),
        .core_wait_o    (core_wait_o),
        .core_addr_o    (core_addr_o),
        .core_out_o     (core_out_o),
        .inv_i          (inv_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110) return 32'hA + ((a - 32'h100) >> 2);
        return (a * 32'h0100_0193) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % SETS);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_vld[set_of(a)] && (m_line[set_of(a)] == line_of(a));
    endfunction

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) m_vld[s] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wait"},     {31'b0, core_wait_o}, 32'h1);
        chk({tag, "_addr"},     core_addr_o,          32'h0);
        chk({tag, "_out"},      core_out_o,           32'h0);
        chk({tag, "_req"},      {31'b0, mem_req_o},   32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o,           32'h0);
    endtask

    // Answers one refill. Optional events by beat number (-1 = none):
    // inv_beat pulses inv_i, redir_beat redirects the core, rst_beat resets.
    task automatic serve(input logic [31:0] exp_line, input int inv_beat,
                         input int redir_beat, input logic [31:0] rpc, input int rst_beat);
        int cyc = 0;
        while (!mem_req_o && cyc < 20) begin
            step();
            cyc++;
        end
        chk("miss_req", {31'b0, mem_req_o}, 32'h1);
        chk("miss_addr", mem_addr_o, exp_line);
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("req_hold", {31'b0, mem_req_o}, 32'h1);
            chk("addr_hold", mem_addr_o, exp_line);
        end
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int b = 0; b < LINE_WORDS; b++) begin
            repeat ($urandom_range(0, 2)) begin
                mem_rdata_i = $urandom;
                step();
                chk("refill_req_low", {31'b0, mem_req_o}, 32'h0);
                chk("refill_wait", {31'b0, core_wait_o}, 32'h1);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(exp_line + 32'(4 * b));
            if (b == rst_beat) begin
                rst_ni = 1'b0;
                #1;
                chk_reset_outputs("rst_mid");
                step();
                rst_ni = 1'b1;
                repeat (3) step();   // stray beats after release
                mem_rvalid_i = 1'b0;
                model_flush();
                cur_pc = 32'h0;
                return;
            end
            if (b == inv_beat) inv_i = 1'b1;
            if (b == redir_beat) begin
                core_request_i = 1'b1;
                core_pc_i      = rpc;
                cur_pc         = rpc;
            end
            step();
            mem_rvalid_i   = 1'b0;
            inv_i          = 1'b0;
            core_request_i = 1'b0;
            if (b < LINE_WORDS - 1) chk("beat_wait", {31'b0, core_wait_o}, 32'h1);
        end
        if (inv_beat >= 0 && inv_beat < LINE_WORDS) begin
            model_flush();
        end else begin
            m_vld[set_of(exp_line)]  = 1'b1;
            m_line[set_of(exp_line)] = exp_line;
        end
    endtask

    // Services whatever miss is pending on cur_pc, then checks the hit.
    task automatic settle();
        for (int k = 0; k < 3; k++) begin
            if (model_hit(cur_pc)) break;
            chk("pending_miss_wait", {31'b0, core_wait_o}, 32'h1);
            serve(line_of(cur_pc), -1, -1, 32'h0, -1);
        end
        chk("hit_wait", {31'b0, core_wait_o}, 32'h0);
        chk("hit_addr", core_addr_o, cur_pc);
        chk("hit_data", core_out_o, mem_word(cur_pc));
        chk("hit_no_req", {31'b0, mem_req_o}, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] pc, input int inv_beat,
                         input int redir_beat, input logic [31:0] rpc, input int rst_beat);
        bit h;
        h = model_hit(pc);
        core_request_i = 1'b1;
        core_pc_i      = pc;
        step();
        core_request_i = 1'b0;
        core_pc_i      = $urandom;
        cur_pc         = pc;
        chk("fetch_addr", core_addr_o, pc);
        chk("fetch_wait", {31'b0, core_wait_o}, {31'b0, ~h});
        if (!h) serve(line_of(pc), inv_beat, redir_beat, rpc, rst_beat);
        settle();
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] rpc;
        int r;
        rst_ni = 1'b0;
        core_request_i = 1'b0;
        core_pc_i = 32'h0;
        inv_i = 1'b0;
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        model_flush();
        cur_pc = 32'h0;
        #2;
        chk_reset_outputs("reset");
        step();
        step();
        rst_ni = 1'b1;
        // Out of reset addr_q=0 misses, so line 0 is refilled first.
        settle();

        // Cold miss, then hit streaming on the same line.
        fetch(32'h100, -1, -1, 32'h0, -1);
        chk("cold_word0", core_out_o, 32'hA);
        fetch(32'h104, -1, -1, 32'h0, -1);
        chk("stream_b", core_out_o, 32'hB);
        fetch(32'h108, -1, -1, 32'h0, -1);
        chk("stream_c", core_out_o, 32'hC);
        fetch(32'h10C, -1, -1, 32'h0, -1);
        chk("stream_d", core_out_o, 32'hD);

        // Conflict eviction in set 0x10.
        fetch(32'h500, -1, -1, 32'h0, -1);
        fetch(32'h100, -1, -1, 32'h0, -1);

        // Redirect to a resident line while 0x200 refills.
        fetch(32'h200, -1, 1, 32'h104, -1);
        chk("redir_hit_addr", core_addr_o, 32'h104);
        fetch(32'h200, -1, -1, 32'h0, -1);

        // Flush mid-refill and on the final beat.
        fetch(32'h300, 1, -1, 32'h0, -1);
        fetch(32'h100, -1, -1, 32'h0, -1);
        fetch(32'h344, 3, -1, 32'h0, -1);
        fetch(32'h200, -1, -1, 32'h0, -1);

        // Reset during beat 2 of a refill.
        fetch(32'h600, -1, -1, 32'h0, 2);
        fetch(32'h104, -1, -1, 32'h0, -1);

        // Randomized traffic over a few conflicting sets.
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(14, 17)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            rpc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(14, 17)) << 4);
            if (r == 0) begin
                inv_i = 1'b1;
                step();
                inv_i = 1'b0;
                model_flush();
                chk("inv_idle_wait", {31'b0, core_wait_o}, 32'h1);
                settle();
            end else if (r == 1) begin
                fetch(pc, -1, $urandom_range(0, 3), rpc, -1);
            end else if (r == 2) begin
                fetch(pc, $urandom_range(0, 3), -1, 32'h0, -1);
            end else begin
                fetch(pc, -1, -1, 32'h0, -1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
